// File: rtl/sqrt_arbiter_pkg.sv
// rtl/sqrt_arbiter_pkg.sv - shared types and default widths for the sqrt arbiter
//
// Package sqrt_arb_pkg
//   sqrt_arb_state_t : sequencer states (IDLE/ISSUE/WAIT/RESP)
//   SQRT_DATA_W      : default operand width
//   SQRT_RES_W       : default root width (half the operand width)
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sqrt_arb_state_t;

    localparam int SQRT_DATA_W = 64;
    localparam int SQRT_RES_W  = 32;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// rtl/sqrt_arbiter_if.sv - requester and core handshake bundle for the sqrt arbiter
//
// Interface sqrt_arb_if #(NREQ, DATA_W, RES_W)
//   req_valid/req_data/req_ready : per-requester operand channel (data packed, requester i at [i*DATA_W +: DATA_W])
//   rsp_valid/rsp_ready          : per-requester result channel, one-hot valid
//   rsp_root/rsp_err             : shared result bus and watchdog-abort flag
//   core_start/core_data         : start pulse and operand to the sqrt core
//   core_done/core_root          : completion pulse and root from the sqrt core
// Modports: slave = arbiter side, master = requesters plus core side.
interface sqrt_arb_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int RES_W  = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [RES_W-1:0]       rsp_root;
    logic                   rsp_err;
    logic                   core_start;
    logic [DATA_W-1:0]      core_data;
    logic                   core_done;
    logic [RES_W-1:0]       core_root;

    modport slave (
        input  req_valid, req_data, rsp_ready, core_done, core_root,
        output req_ready, rsp_valid, rsp_root, rsp_err, core_start, core_data
    );

    modport master (
        output req_valid, req_data, rsp_ready, core_done, core_root,
        input  req_ready, rsp_valid, rsp_root, rsp_err, core_start, core_data
    );
endinterface

// File: rtl/sqrt_arbiter_rr_grant.sv
// rtl/sqrt_arbiter_rr_grant.sv - combinational round-robin grant picker
//
// Module sqrt_rr_grant #(NREQ, IDX_W)
//   req     in  NREQ  : request vector
//   ptr     in  IDX_W : highest-priority index (must be < NREQ)
//   gnt     out NREQ  : one-hot grant, first request at or after ptr (wrapping)
//   gnt_idx out IDX_W : index of the granted requester
//   gnt_any out 1     : at least one request present
module sqrt_rr_grant #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk from ptr upward, wrapping once past NREQ-1.
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(j);
                gnt[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin sequencer sharing one iterative sqrt core
//
// Module sqrt_arbiter #(NREQ, DATA_W, RES_W, TIMEOUT_CYC)
//   clk         in  : rising-edge clock
//   rst         in  : synchronous active-high reset
//   bus         if  : sqrt_arb_if.slave (requester channels and core handshake)
//   timeout_err out : sticky watchdog flag
// Optional feature macro: SQRT_ARB_TIMEOUT_EN (WAIT watchdog of TIMEOUT_CYC cycles).
// Without it WAIT is unbounded and rsp_err/timeout_err are tied low.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DATA_W      = SQRT_DATA_W,
    parameter int RES_W       = SQRT_RES_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic      clk,
    input  logic      rst,
    sqrt_arb_if.slave bus,
    output logic      timeout_err
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || RES_W * 2 != DATA_W || TIMEOUT_CYC < 1) begin : g_param_check
        $error("sqrt_arbiter: illegal parameter set");
    end

    sqrt_arb_state_t   state;
    sqrt_arb_state_t   state_nx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner_q;
    logic [DATA_W-1:0] op_q;
    logic [RES_W-1:0]  root_q;
    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              wd_fire;

    sqrt_rr_grant #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_grant (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            timeout_q;

    // Counter only advances in WAIT, so it restarts for every operation.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A done pulse in the final cycle still wins over the watchdog.
    assign wd_fire = (state == WAIT) && !bus.core_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.core_done || wd_fire) state_nx = RESP;
            RESP:    if (bus.rsp_ready[owner_q]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            owner_q <= '0;
            rr_ptr  <= '0;
            root_q  <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && gnt_any) begin
                op_q    <= bus.req_data[int'(gnt_idx) * DATA_W +: DATA_W];
                owner_q <= gnt_idx;
                rr_ptr  <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef SQRT_ARB_TIMEOUT_EN
                err_q   <= 1'b0;
`endif
            end
            if (state == WAIT && bus.core_done) begin
                root_q <= bus.core_root;
            end
`ifdef SQRT_ARB_TIMEOUT_EN
            else if (wd_fire) begin
                root_q <= '0;
                err_q  <= 1'b1;
            end
`endif
        end
    end

    // Outputs
    always_comb begin
        bus.req_ready  = '0;
        bus.rsp_valid  = '0;
        bus.core_start = 1'b0;
        bus.core_data  = op_q;
        bus.rsp_root   = root_q;
        bus.rsp_err    = 1'b0;
        case (state)
            IDLE:  bus.req_ready  = gnt;
            ISSUE: bus.core_start = 1'b1;
            RESP: begin
                bus.rsp_valid = NREQ'(1) << owner_q;
`ifdef SQRT_ARB_TIMEOUT_EN
                bus.rsp_err   = err_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - directed self-checking bench for sqrt_arbiter
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int DATA_W = 64;
    localparam int RES_W  = 32;
    localparam int L      = 33;
    localparam int TO     = 256;

    logic clk = 1'b0;
    logic rst;
    logic timeout_err;
    bit   core_hang = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    sqrt_arb_if #(.NREQ(NREQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    sqrt_arbiter #(
        .NREQ        (NREQ),
        .DATA_W      (DATA_W),
        .RES_W       (RES_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= v) r = t;
        end
        return r;
    endfunction

    // Behavioural core: done pulse L cycles after the start cycle.
    logic [63:0] m_op;
    int          m_cnt;
    bit          m_busy;
    always @(posedge clk) begin
        bus.core_done <= 1'b0;
        if (!m_busy) begin
            if (bus.core_start && !core_hang) begin
                m_busy <= 1'b1;
                m_op   <= bus.core_data;
                m_cnt  <= 1;
            end
        end else if (m_cnt == L - 1) begin
            bus.core_done <= 1'b1;
            bus.core_root <= isqrt(m_op);
            m_busy        <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Called at the ISSUE-cycle negedge; returns cycles until rsp_valid and extra starts seen.
    task automatic wait_rsp(output int n, output int starts);
        n = 0;
        starts = 0;
        while (bus.rsp_valid == '0 && n < 600) begin
            @(negedge clk);
            n++;
            if (bus.core_start) starts++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.core_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: req_ready=%b rsp_valid=%b core_start=%b required 0", bus.req_ready, bus.rsp_valid, bus.core_start);
        end
        vectors++;
        if (bus.core_data !== 64'd0 || bus.rsp_root !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: core_data=%0h rsp_root=%0h required 0", bus.core_data, bus.rsp_root);
        end
        vectors++;
        if (bus.rsp_err !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: rsp_err=%b timeout_err=%b required 0", bus.rsp_err, timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n, s;
        bus.req_data[0 +: 64] = 64'd16;
        bus.req_valid = 4'b0001;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_ready: got %b required 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        vectors++;
        if (bus.core_start !== 1'b1 || bus.core_data !== 64'd16) begin
            miscompares++;
            $display("FAIL single_start: core_start=%b core_data=%0d required 1/16", bus.core_start, bus.core_data);
        end
        wait_rsp(n, s);
        vectors++;
        if (n !== L + 1 || s !== 0) begin
            miscompares++;
            $display("FAIL single_latency: cycles=%0d extra_starts=%0d required %0d/0", n, s, L + 1);
        end
        vectors++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_root !== 32'd4 || bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rsp: rsp_valid=%b root=%0d err=%b required 0001/4/0", bus.rsp_valid, bus.rsp_root, bus.rsp_err);
        end
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 4'b0) begin
            miscompares++;
            $display("FAIL single_release: rsp_valid=%b required 0000", bus.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_root [4];
        int n, s;
        exp_root = '{32'd20, 32'd256, 32'd4000, 32'h3FFF_FFFF};
        do_reset();
        bus.req_data[0*64 +: 64] = 64'd400;
        bus.req_data[1*64 +: 64] = 64'h1_0001;
        bus.req_data[2*64 +: 64] = 64'd16000000;
        bus.req_data[3*64 +: 64] = 64'h0FFF_FFFF_FFFF_FFFF;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (bus.req_ready !== 4'(1 << k)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b required %b", k, bus.req_ready, 4'(1 << k));
            end
            @(negedge clk);
            bus.req_valid[k] = 1'b0;
            wait_rsp(n, s);
            vectors++;
            if (bus.rsp_valid !== 4'(1 << k) || bus.rsp_root !== exp_root[k]) begin
                miscompares++;
                $display("FAIL rr_rsp%0d: rsp_valid=%b root=%0h required %b/%0h", k, bus.rsp_valid, bus.rsp_root, 4'(1 << k), exp_root[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n, s;
        bus.req_data[1*64 +: 64] = 64'd4611686014132420609;
        bus.req_data[3*64 +: 64] = 64'd1;
        bus.rsp_ready = 4'b1101;
        bus.req_valid = 4'b1010;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_grant: got %b required 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        wait_rsp(n, s);
        vectors++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_root !== 32'h7FFF_FFFF) begin
            miscompares++;
            $display("FAIL bp_rsp: rsp_valid=%b root=%0h required 0010/7fffffff", bus.rsp_valid, bus.rsp_root);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_root !== 32'h7FFF_FFFF || bus.req_ready !== 4'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: rsp_valid=%b root=%0h req_ready=%b required 0010/7fffffff/0000", i, bus.rsp_valid, bus.rsp_root, bus.req_ready);
            end
        end
        bus.rsp_ready = 4'b1111;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_next_grant: got %b required 1000", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(n, s);
        vectors++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_root !== 32'd1) begin
            miscompares++;
            $display("FAIL bp_rsp3: rsp_valid=%b root=%0d required 1000/1", bus.rsp_valid, bus.rsp_root);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, s;
        bit seen;
        bus.req_data[1*64 +: 64] = 64'd100;
        bus.req_valid = 4'b0010;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL rm_grant: got %b required 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (bus.rsp_valid !== 4'b0 || bus.core_data !== 64'd0 || bus.rsp_root !== 32'd0 || bus.core_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_outputs: rsp_valid=%b core_data=%0h root=%0h start=%b required 0", bus.rsp_valid, bus.core_data, bus.rsp_root, bus.core_start);
        end
        n = 0;
        seen = 1'b0;
        while (!bus.core_done && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid != '0) seen = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) seen = 1'b1;
        end
        vectors++;
        if (n >= 100 || seen) begin
            miscompares++;
            $display("FAIL rm_late_done: done_wait=%0d rsp_seen=%b required <100/0", n, seen);
        end
        bus.req_data[1*64 +: 64] = 64'd9;
        bus.req_data[3*64 +: 64] = 64'd64;
        bus.req_valid = 4'b1010;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL rm_ptr_reset: got %b required 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(n, s);
        vectors++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_root !== 32'd3) begin
            miscompares++;
            $display("FAIL rm_rsp: rsp_valid=%b root=%0d required 0010/3", bus.rsp_valid, bus.rsp_root);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int n, s;
        bus.req_data[2*64 +: 64] = 64'd49;
        bus.req_data[0*64 +: 64] = 64'd25;
        bus.req_valid = 4'b0100;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL fair_first: got %b required 0100", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0101;
        wait_rsp(n, s);
        vectors++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_root !== 32'd7) begin
            miscompares++;
            $display("FAIL fair_rsp2: rsp_valid=%b root=%0d required 0100/7", bus.rsp_valid, bus.rsp_root);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL fair_req0: got %b required 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0100;
        wait_rsp(n, s);
        vectors++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_root !== 32'd5) begin
            miscompares++;
            $display("FAIL fair_rsp0: rsp_valid=%b root=%0d required 0001/5", bus.rsp_valid, bus.rsp_root);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL fair_back_to_2: got %b required 0100", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(n, s);
        @(negedge clk);
    endtask

`ifdef SQRT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n, s;
        core_hang = 1'b1;
        bus.req_data[0 +: 64] = 64'd16;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(n, s);
        vectors++;
        if (n !== TO + 1 || bus.rsp_valid !== 4'b0001 || bus.rsp_root !== 32'd0 || bus.rsp_err !== 1'b1 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rsp: cycles=%0d rsp_valid=%b root=%0h err=%b tmo=%b required %0d/0001/0/1/1", n, bus.rsp_valid, bus.rsp_root, bus.rsp_err, timeout_err, TO + 1);
        end
        core_hang = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (timeout_err !== 1'b1 || bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_sticky: tmo=%b rsp_err=%b required 1/0", timeout_err, bus.rsp_err);
        end
        do_reset();
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: tmo=%b required 0", timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fairness();
`ifdef SQRT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin arbiter and sequencer that shares one iterative 64-bit integer square-root core among `NREQ` requesters. It accepts operands over per-requester valid/ready channels and issues each one to the core with a start/done handshake. It returns the 32-bit floor root to the requester that issued it. It sits between the requesting datapaths and the single `sqrt` instance, so that instance is never driven directly by more than one client.

## Interface

Parameters:

- `NREQ`, 4: number of requesters, 2..8.
- `DATA_W`, 64: operand width.
- `RES_W`, 32: root width; must equal `DATA_W/2`.
- `TIMEOUT_CYC`, 256: watchdog limit in cycles. Used only with `SQRT_ARB_TIMEOUT_EN`.

Ports:

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_data` in `NREQ*DATA_W`: packed operands; requester i is at `[i*DATA_W +: DATA_W]`.
- `req_ready` out `NREQ`: one-hot accept strobe.
- `rsp_valid` out `NREQ`: one-hot result valid, routed to the owner of the result.
- `rsp_ready` in `NREQ`: per-requester result accept.
- `rsp_root` out `RES_W`: shared result bus.
- `rsp_err` out 1: result was aborted by the watchdog.
- `core_start` out 1: one-cycle start pulse to the sqrt core.
- `core_data` out `DATA_W`: operand to the core, held stable from `core_start` until `core_done`.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_root` in `RES_W`: core result, valid while `core_done` is high.
- `timeout_err` out 1: sticky watchdog flag.

## Operation

- The FSM has states IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If any `req_valid` is high, the round-robin grant picks the first requester at or after `rr_ptr` (wrapping at `NREQ`).
  - `req_ready[g]` is high combinationally in the same cycle. The operand is captured into `op_q` and `g` into `owner_q`.
  - `rr_ptr` becomes `(g+1) mod NREQ`. The next state is ISSUE.
- **ISSUE**
  - `core_start` is 1 for exactly this cycle; `core_data=op_q`. The next state is WAIT.
- **WAIT**
  - On `core_done`, `core_root` is latched into `root_q` and the next state is RESP.
  - `core_done` seen in any other state is ignored.
- **RESP**
  - `rsp_valid[owner_q]` is high and `rsp_root=root_q`. Both hold until `rsp_ready[owner_q]` is high.
  - The next state is IDLE. `rsp_ready` from any non-owner is ignored.
- Only one operation is outstanding. `req_ready` is 0 in every state except IDLE.
- Requesters with `req_valid` held high are served in rotation; no requester waits more than `NREQ-1` grants.
- `core_data` holds its value outside ISSUE/WAIT; it is not forced to 0.

## Timing

- Reset values:
  - state=IDLE, `rr_ptr`=0.
  - `op_q`=0, `root_q`=0, `owner_q`=0.
  - All outputs 0, including `timeout_err`.
- Reset mid-operation aborts the operation with no response. A late `core_done` after reset is ignored.
- Latency, with accept at cycle T:
  - `core_start` at T+1.
  - With `core_done` at T+1+L, `rsp_valid` is high at T+2+L.
- A response handshake at cycle R returns the FSM to IDLE at R+1, so the next accept is no earlier than R+1.
  - Minimum accept-to-accept spacing is L+3 cycles with `rsp_ready` held high.
- Simultaneous requests from all requesters with `rr_ptr=0` are granted in order 0,1,2,3,0,…

## Configuration

- `SQRT_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If it reaches `TIMEOUT_CYC` without `core_done`, the FSM enters RESP with `root_q=0` and `rsp_err=1`.
  - `timeout_err` is set and stays set until `rst`.
- `SQRT_ARB_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely; there is no counter.
  - `rsp_err` and `timeout_err` are tied to 0.

## Structure

- Package `sqrt_arb_pkg` holds:
  - the state enum `sqrt_arb_state_t` (IDLE/ISSUE/WAIT/RESP);
  - default-width constants `SQRT_DATA_W=64` and `SQRT_RES_W=32`.
- Sub-module `sqrt_rr_grant` takes `req[NREQ]` and `ptr` and produces a one-hot grant and its index. It is purely combinational.

## Test plan

- Single requester 0, `req_data=16`, behavioural core with L=33 → `req_ready[0]` in the same cycle, one `core_start`, `rsp_valid[0]` with `rsp_root=4` exactly L+1 cycles after `core_start`.
- Requesters 0–3 all valid at once with operands 400, 0x10001, 16000000 and 0x0FFF_FFFF_FFFF_FFFF:
  - grants in order 0,1,2,3;
  - roots 20, 256, 4000 and 0x3FFF_FFFF, each on its own `rsp_valid` bit.
- Operand 4611686014132420609 with `rsp_ready` held low for 10 cycles → `rsp_valid` and `rsp_root=0x7FFF_FFFF` stay stable for those cycles; no new `req_ready` until the handshake.
- `rst` asserted during WAIT, then `core_done` pulses → outputs return to 0, no `rsp_valid`, and the next request is granted starting from `rr_ptr=0`.
- With `SQRT_ARB_TIMEOUT_EN` and `TIMEOUT_CYC=256`, the core never asserts `core_done` → `rsp_valid` high with `rsp_root=0` and `rsp_err=1` 256 cycles into WAIT; `timeout_err` stays 1 until `rst`.
- Requester 2 continuously valid while requester 0 pulses valid → requester 0 is granted within one grant of its request, so requester 2 cannot starve it.
